// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between decode and the immediate-extension stage.
// master drives the immediate and consumes the extended value; slave is the extension unit.
interface imm_extend_pipe_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [1:0]       out_mode;
   logic [1:0]       occupancy;

   modport master (
      output in_valid, in_imm, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_mode, occupancy
   );

   modport slave (
      input  in_valid, in_imm, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_mode, occupancy
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extension (sign/zero/upper/branch-offset) behind a registered output plus skid entry.
// Latency: one cycle from input transfer to out_valid.
// Backpressure: in_ready is registered and drops only when both entries are held.
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   imm_extend_pipe_if.slave bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0]       mode;
      logic [OUT_W-1:0] data;
   } entry_t;

   state_t           state_q, state_d;
   entry_t           out_q, skid_q, new_e;
   logic             in_ready_q;
   logic             in_fire, out_fire;
   logic             load_out, load_skid, move_skid;
   logic [OUT_W-1:0] sx, zx;

   assign in_fire  = bus.in_valid && in_ready_q;
   assign out_fire = (state_q != EMPTY) && bus.out_ready;

   // Branch offset reuses the sign-extended value; the shift drops the top two sign copies.
   always_comb begin
      sx         = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
      zx         = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
      new_e.mode = bus.in_mode;
      case (bus.in_mode)
         2'b00:   new_e.data = sx;
         2'b01:   new_e.data = zx;
         2'b10:   new_e.data = zx << (OUT_W-IN_W);
         default: new_e.data = sx << 2;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               load_out = 1'b1;
               state_d  = ONE;
            end
         end
         ONE: begin
            case ({in_fire, out_fire})
               2'b10: begin
                  load_skid = 1'b1;
                  state_d   = TWO;
               end
               2'b01:   state_d  = EMPTY;
               2'b11:   load_out = 1'b1;
               default: state_d  = ONE;
            endcase
         end
         TWO: begin
            if (out_fire) begin
               move_skid = 1'b1;
               state_d   = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // in_ready comes out of reset low so the first capture happens only after a clean edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b0;
         out_q      <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
         if (load_out)
            out_q <= new_e;
         else if (move_skid)
            out_q <= skid_q;
         if (load_skid)
            skid_q <= new_e;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.out_data  = out_q.data;
   assign bus.out_mode  = out_q.mode;
   assign bus.occupancy = state_q;

endmodule
